// File: rtl/curr_ctrl_dbg_pkg.sv
// curr_ctrl_dbg_pkg
//   Shared types and constants for the current-control debug trace capture.
//   - dbg_state_e : capture FSM states
//   - DBG_*       : default RAM geometry (512 x 32)
package curr_ctrl_dbg_pkg;

  localparam int DBG_ADDR_W = 9;
  localparam int DBG_DATA_W = 32;
  localparam int DBG_DEPTH  = 512;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE
  } dbg_state_e;

endpackage

// File: rtl/curr_ctrl_dbg_decim.sv
// curr_ctrl_dbg_decim
//   Decimation counter for the trace capture. Counts valid samples and
//   flags every (decim+1)th one as accepted.
//   Ports:
//     clk, reset_n      : clock, async active-low reset
//     clr_i             : restart counting from zero (capture start)
//     en_i              : capture is accepting samples this cycle
//     sample_valid_i    : sample strobe
//     decim_i [7:0]     : decimation ratio minus one
//     accept_o          : this valid sample is kept (combinational)
module curr_ctrl_dbg_decim (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       sample_valid_i,
  input  logic [7:0] decim_i,
  output logic       accept_o
);

  logic [7:0] cnt_q, cnt_d;

  assign accept_o = en_i & sample_valid_i & (cnt_q == decim_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (en_i && sample_valid_i) cnt_d = accept_o ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/curr_ctrl_debug_capture.sv
// curr_ctrl_debug_capture
//   Trace-capture engine writing decimated current-loop samples into the
//   debug RAM as a circular buffer with a pre-trigger window.
//   Ports:
//     clk, reset_n                 : clock, async active-low reset
//     arm / abort                  : start / cancel pulses (abort wins)
//     pre_count                    : pre-trigger words kept, latched at arm
//     decim                        : keep every (decim+1)th valid sample
//     sample_valid / sample_data   : sample stream
//     trig_in                      : trigger level, rising edge is the event
//     ram_*                        : RAM write port (single-cycle writes)
//     busy / done                  : capture status
//     trig_addr                    : address of first post-trigger sample
//     wrapped                      : older data was overwritten this capture
module curr_ctrl_debug_capture
  import curr_ctrl_dbg_pkg::*;
#(
  parameter int ADDR_W = DBG_ADDR_W,
  parameter int DATA_W = DBG_DATA_W,
  parameter int DEPTH  = DBG_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   pre_count,
  input  logic [7:0]          decim,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  input  logic                trig_in,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic                wrapped
);

  localparam logic [ADDR_W-1:0] PTR_MAX   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  dbg_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   pre_lat_q, pre_lat_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;      // fill count up, then post count down
  logic                wrapped_q, wrapped_d;
  logic                trig_prev_q;
  logic                wr_vld_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                clken_q;

  logic                active, arm_go, accept, trig_rise, last_wr;
  logic [ADDR_W:0]     post_left;

  assign active    = (state_q == FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign arm_go    = arm && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign trig_rise = trig_in && !trig_prev_q;
  // pre_lat never exceeds DEPTH-1 (its width is ADDR_W), so this is >= 1.
  assign post_left = DEPTH_CNT - {1'b0, pre_lat_q};

  curr_ctrl_dbg_decim u_decim (
    .clk            (clk),
    .reset_n        (reset_n),
    .clr_i          (arm_go),
    .en_i           (active && !abort),
    .sample_valid_i (sample_valid),
    .decim_i        (decim),
    .accept_o       (accept)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wrapped_d   = wrapped_q;
    trig_addr_d = trig_addr_q;
    pre_lat_d   = pre_lat_q;
    cnt_d       = cnt_q;
    last_wr     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (arm_go) begin
          wr_ptr_d  = '0;
          wrapped_d = 1'b0;
          cnt_d     = '0;
          // DEPTH == 2**ADDR_W, so pre_count is already within DEPTH-1.
          pre_lat_d = pre_count;
          state_d   = (pre_count == '0) ? WAIT_TRIG : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == {1'b0, pre_lat_q}) state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (trig_rise) begin
          // Next accepted sample lands at wr_ptr; a sample accepted this
          // same cycle is itself the first post-trigger sample.
          trig_addr_d = wr_ptr_q;
          state_d     = POST;
          cnt_d       = post_left;
          if (accept) begin
            cnt_d = post_left - 1'b1;
            if (post_left == CNT_ONE) begin
              last_wr = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      POST: begin
        if (accept) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            last_wr = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      // The pointer rolling over on the final write overwrites nothing, so
      // only a rollover that is followed by more writes counts as a wrap.
      if ((wr_ptr_q == PTR_MAX) && !last_wr) wrapped_d = 1'b1;
    end

    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      trig_addr_q <= '0;
      pre_lat_q   <= '0;
      cnt_q       <= '0;
      trig_prev_q <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      clken_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      trig_addr_q <= trig_addr_d;
      pre_lat_q   <= pre_lat_d;
      cnt_q       <= cnt_d;
      trig_prev_q <= trig_in;
      wr_vld_q    <= accept;
      clken_q     <= 1'b1;
      if (accept) begin
        wr_addr_q <= wr_ptr_q;
        wr_data_q <= sample_data;
      end
    end
  end

  assign ram_address    = wr_addr_q;
  assign ram_chipselect = wr_vld_q;
  assign ram_write      = wr_vld_q;
  assign ram_byteenable = {(DATA_W/8){wr_vld_q}};
  assign ram_writedata  = wr_data_q;
  assign ram_clken      = clken_q;
  assign busy           = active;
  assign done           = (state_q == DONE);
  assign trig_addr      = trig_addr_q;
  assign wrapped        = wrapped_q;

endmodule

// File: tb/tb_curr_ctrl_debug_capture.sv
// tb_curr_ctrl_debug_capture
//   Randomized and directed stimulus against a capture-level reference model
//   (sample counts since arm, trigger index, end index) checked every cycle.
module tb_curr_ctrl_debug_capture;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0, abort = 1'b0;
  logic [AW-1:0] pre_count = '0;
  logic [7:0]    decim = '0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          trig_in = 1'b0;

  logic [AW-1:0]   ram_address;
  logic            ram_chipselect, ram_write, ram_clken, busy, done, wrapped;
  logic [DW/8-1:0] ram_byteenable;
  logic [DW-1:0]   ram_writedata;
  logic [AW-1:0]   trig_addr;

  always #5 clk = ~clk;

  curr_ctrl_debug_capture dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .pre_count(pre_count), .decim(decim), .sample_valid(sample_valid),
    .sample_data(sample_data), .trig_in(trig_in),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .busy(busy), .done(done), .trig_addr(trig_addr), .wrapped(wrapped)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a capture is "samples since arm" plus an end index.
  bit          m_busy, m_done, m_wrapped, m_prev, m_trig_seen;
  int          m_pre, m_acc, m_nvalid, m_trig_idx, m_trig_addr;
  bit          e_wr;
  int          e_addr;
  logic [31:0] e_data;

  int          n_wr, vidx;
  logic [31:0] mem [DEPTH];
  logic [31:0] wlog [$];

  function automatic void model_clear();
    m_busy = 0; m_done = 0; m_wrapped = 0; m_prev = 0; m_trig_seen = 0;
    m_pre = 0; m_acc = 0; m_nvalid = 0; m_trig_idx = 0; m_trig_addr = 0;
  endfunction

  function automatic void model_step();
    bit take, fin;
    take = 0; fin = 0; e_wr = 0;
    if (abort) begin
      m_busy = 0; m_done = 0;
    end else if (arm && !m_busy) begin
      m_busy = 1; m_done = 0; m_wrapped = 0; m_trig_seen = 0;
      m_acc = 0; m_nvalid = 0; m_pre = int'(pre_count);
    end else if (m_busy) begin
      if (!m_trig_seen && m_acc >= m_pre && trig_in && !m_prev) begin
        m_trig_seen = 1; m_trig_idx = m_acc; m_trig_addr = m_acc % DEPTH;
      end
      if (sample_valid) begin
        take = ((m_nvalid % (int'(decim) + 1)) == int'(decim));
        m_nvalid++;
      end
      if (take) begin
        e_wr = 1; e_addr = m_acc % DEPTH; e_data = sample_data;
        m_acc++;
        fin = m_trig_seen && (m_acc == m_trig_idx + DEPTH - m_pre);
        if (e_addr == DEPTH - 1 && !fin) m_wrapped = 1;
        if (fin) begin m_busy = 0; m_done = 1; end
      end
    end
    m_prev = trig_in;
  endfunction

  // One clock: model consumes current inputs, DUT sampled on the falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("ram_write", ram_write, e_wr);
    chk("ram_chipselect", ram_chipselect, e_wr);
    chk("ram_byteenable", ram_byteenable, e_wr ? 4'hF : 4'h0);
    if (e_wr) begin
      chk("ram_address", ram_address, e_addr);
      chk("ram_writedata", ram_writedata, e_data);
    end
    if (ram_write) begin
      n_wr++;
      mem[ram_address] = ram_writedata;
      wlog.push_back(ram_writedata);
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("wrapped", wrapped, m_wrapped);
    chk("trig_addr", trig_addr, m_trig_addr);
    chk("ram_clken", ram_clken, 1);
  endtask

  task automatic arm_capture(input int pre, input int dec);
    pre_count = AW'(pre); decim = 8'(dec);
    sample_valid = 0; arm = 1;
    n_wr = 0; vidx = 0; wlog.delete();
    cycle();
    arm = 0;
  endtask

  task automatic push_idx();
    sample_valid = 1; sample_data = vidx; vidx++;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ram_write"}, ram_write, 0);
    chk({tag, "_ram_cs"}, ram_chipselect, 0);
    chk({tag, "_ram_be"}, ram_byteenable, 0);
    chk({tag, "_ram_addr"}, ram_address, 0);
    chk({tag, "_ram_data"}, ram_writedata, 0);
    chk({tag, "_ram_clken"}, ram_clken, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_trig_addr"}, trig_addr, 0);
    chk({tag, "_wrapped"}, wrapped, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #23;
    check_zero_outputs("rst");
    @(negedge clk);
    reset_n = 1;

    // Basic capture: pre 100, trigger after 300 accepted samples.
    arm_capture(100, 0);
    for (int c = 0; c < 3000 && m_busy; c++) begin
      push_idx();
      trig_in = (m_acc >= 300);
      cycle();
    end
    chk("basic_done", done, 1);
    chk("basic_trig_addr", trig_addr, 300);
    chk("basic_wrapped", wrapped, 1);
    chk("basic_nwr", n_wr, 712);
    chk("basic_mem299", mem[299], 299);
    sample_valid = 0; trig_in = 0;
    cycle();

    // Decimation by 4.
    arm_capture(20, 3);
    for (int c = 0; c < 40; c++) begin push_idx(); cycle(); end
    chk("decim_nwr", n_wr, 10);
    if (wlog.size() >= 3) begin
      chk("decim_w0", wlog[0], 3);
      chk("decim_w1", wlog[1], 7);
      chk("decim_w2", wlog[2], 11);
    end
    sample_valid = 0; abort = 1; cycle(); abort = 0;

    // Trigger activity during FILL, level held high into WAIT_TRIG.
    arm_capture(50, 0);
    for (int c = 0; c < 80; c++) begin
      push_idx();
      trig_in = (m_acc == 10) || (m_acc >= 40);
      cycle();
    end
    chk("fill_busy", busy, 1);
    chk("fill_no_trig", trig_addr, 300);
    push_idx(); trig_in = 0; cycle();
    push_idx(); trig_in = 1; cycle();
    chk("fill_trig_addr", trig_addr, 81);
    for (int c = 0; c < 3000 && m_busy; c++) begin push_idx(); cycle(); end
    chk("fill_done", done, 1);
    sample_valid = 0; trig_in = 0; cycle();

    // pre_count = 0: trigger on the very first write.
    arm_capture(0, 0);
    for (int c = 0; c < 3000 && m_busy; c++) begin
      push_idx(); trig_in = 1; cycle();
    end
    chk("pre0_trig_addr", trig_addr, 0);
    chk("pre0_wrapped", wrapped, 0);
    chk("pre0_nwr", n_wr, 512);
    chk("pre0_done", done, 1);
    sample_valid = 0; trig_in = 0; cycle();

    // Abort mid-POST, with an ignored arm during POST first.
    arm_capture(30, 0);
    for (int c = 0; c < 200 && !(m_trig_seen && m_acc >= 100); c++) begin
      push_idx(); trig_in = (m_acc >= 60);
      arm = (m_acc == 90); pre_count = 5;
      cycle();
    end
    arm = 0;
    push_idx(); abort = 1; cycle(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_trig_addr", trig_addr, 60);
    n_wr = 0;
    for (int c = 0; c < 5; c++) begin push_idx(); cycle(); end
    chk("abort_no_writes", n_wr, 0);
    trig_in = 0;

    // arm together with abort stays idle.
    arm = 1; abort = 1; push_idx(); cycle();
    arm = 0; abort = 0;
    chk("armabort_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin push_idx(); cycle(); end

    // Asynchronous reset in the middle of a capture.
    arm_capture(10, 0);
    for (int c = 0; c < 30; c++) begin push_idx(); trig_in = (m_acc >= 20); cycle(); end
    #2 reset_n = 0;
    #1 check_zero_outputs("arst");
    model_clear();
    sample_valid = 0; trig_in = 0;
    @(negedge clk);
    reset_n = 1;
    cycle();

    // Randomized captures.
    for (int r = 0; r < 4; r++) begin
      arm_capture(int'($urandom_range(0, 511)), int'($urandom_range(0, 3)));
      if (r == 1) begin
        pre_count = 511;
        cycle(); // arm already taken; no-op for a busy capture
      end
      for (int c = 0; c < 12000 && m_busy; c++) begin
        sample_valid = ($urandom_range(0, 3) != 0);
        sample_data  = $urandom;
        if ($urandom_range(0, 7) == 0) trig_in = ~trig_in;
        arm   = ($urandom_range(0, 49) == 0);
        abort = (r == 3) && ($urandom_range(0, 1999) == 0);
        cycle();
      end
      arm = 0; abort = 0; sample_valid = 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
